uart_frame_rx: RTL and testbench

Receive-side frame controller sitting directly behind the UART receiver. It consumes the receiver's per-byte `rx_done_tick`/`rx_dout` strobe and parses framed packets of the form SOF, LEN, payload, CHECKSUM. Each payload is buffered internally and released to the consumer as a valid/ready byte stream only after the whole frame validates. Malformed, stalled or overrunning traffic is reported through a one-cycle error strobe with a code.

---
 rtl/uart_frame_rx.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: parses SOF/LEN/payload[/CHECKSUM] frames from the UART
// receiver byte strobe, buffers the payload, and releases it as a
// valid/ready stream once the frame validates. Errors pulse err_tick.
// Optional feature macro: UART_FRAME_CSUM_EN (checksum byte and err 1).
module uart_frame_rx #(
  parameter int unsigned     DBIT     = 8,
  parameter logic [DBIT-1:0] SOF      = DBIT'(8'hA5),
  parameter int unsigned     MAX_LEN  = 16,
  parameter int unsigned     TO_TICKS = 320
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx_done_tick,
  input  logic [DBIT-1:0] rx_dout,
  input  logic            s_tick,
  output logic            out_valid,
  output logic [DBIT-1:0] out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic            err_tick,
  output logic [1:0]      err_code,
  output logic            busy
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TO_TICKS + 1);

  localparam logic [TW-1:0]   TO_LAST   = TW'(TO_TICKS - 1);
  localparam logic [DBIT-1:0] MAX_LEN_B = DBIT'(MAX_LEN);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_DELIVER = 3'd3;
`ifdef UART_FRAME_CSUM_EN
  localparam logic [2:0] ST_CSUM    = 3'd4;
  localparam logic [1:0] ERR_CSUM   = 2'd1;
`endif

  localparam logic [1:0] ERR_LEN     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  logic [2:0]      state_q,  state_d;
  logic [LW-1:0]   len_q,    len_d;
  logic [LW-1:0]   wr_idx_q, wr_idx_d;
  logic [LW-1:0]   rd_idx_q, rd_idx_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
`ifdef UART_FRAME_CSUM_EN
  logic [DBIT-1:0] sum_q,    sum_d;
`endif
  logic [DBIT-1:0] mem_q [MAX_LEN];
  logic [DBIT-1:0] mem_d [MAX_LEN];

  logic            out_valid_q, out_valid_d;
  logic [DBIT-1:0] out_data_q,  out_data_d;
  logic            out_last_q,  out_last_d;
  logic            err_tick_q,  err_tick_d;
  logic [1:0]      err_code_q,  err_code_d;
  logic            busy_q,      busy_d;
  logic            parsing;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    to_cnt_d   = to_cnt_q;
`ifdef UART_FRAME_CSUM_EN
    sum_d      = sum_q;
`endif
    mem_d      = mem_q;
    err_tick_d = 1'b0;
    err_code_d = err_code_q;
    parsing    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        to_cnt_d = '0;
        if (rx_done_tick && rx_dout == SOF) begin
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        parsing = 1'b1;
        if (rx_done_tick) begin
          to_cnt_d = '0;
          if (rx_dout == '0 || rx_dout > MAX_LEN_B) begin
            err_tick_d = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_IDLE;
          end else begin
            len_d    = LW'(rx_dout);
            wr_idx_d = '0;
            rd_idx_d = '0;
`ifdef UART_FRAME_CSUM_EN
            sum_d    = rx_dout;
`endif
            state_d  = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        parsing = 1'b1;
        if (rx_done_tick) begin
          to_cnt_d                    = '0;
          mem_d[wr_idx_q[IW-1:0]]     = rx_dout;
          wr_idx_d                    = wr_idx_q + LW'(1);
`ifdef UART_FRAME_CSUM_EN
          sum_d                       = sum_q + rx_dout;
          if (wr_idx_q == len_q - LW'(1)) state_d = ST_CSUM;
`else
          if (wr_idx_q == len_q - LW'(1)) state_d = ST_DELIVER;
`endif
        end
      end

`ifdef UART_FRAME_CSUM_EN
      ST_CSUM: begin
        parsing = 1'b1;
        if (rx_done_tick) begin
          to_cnt_d = '0;
          if (rx_dout == sum_q) begin
            state_d = ST_DELIVER;
          end else begin
            err_tick_d = 1'b1;
            err_code_d = ERR_CSUM;
            state_d    = ST_IDLE;
          end
        end
      end
`endif

      ST_DELIVER: begin
        to_cnt_d = '0;
        // Bytes arriving while the buffer drains are dropped, never parsed
        if (rx_done_tick) begin
          err_tick_d = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
        if (out_valid_q && out_ready) begin
          rd_idx_d = rd_idx_q + LW'(1);
          if (out_last_q) state_d = ST_IDLE;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        to_cnt_d = '0;
      end
    endcase

    // Inter-byte timeout; a byte in the same cycle as the final tick wins
    if (parsing && !rx_done_tick && s_tick) begin
      if (to_cnt_q == TO_LAST) begin
        to_cnt_d   = '0;
        state_d    = ST_IDLE;
        err_tick_d = 1'b1;
        err_code_d = ERR_TIMEOUT;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end

    // Stream outputs look ahead at the next state so they are registered
    out_valid_d = (state_d == ST_DELIVER);
    out_last_d  = out_valid_d && (rd_idx_d == len_q - LW'(1));
    out_data_d  = out_valid_d ? mem_d[rd_idx_d[IW-1:0]] : '0;
    busy_d      = (state_d != ST_IDLE);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      to_cnt_q    <= '0;
`ifdef UART_FRAME_CSUM_EN
      sum_q       <= '0;
`endif
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_tick_q  <= 1'b0;
      err_code_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      to_cnt_q    <= to_cnt_d;
`ifdef UART_FRAME_CSUM_EN
      sum_q       <= sum_d;
`endif
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_tick_q  <= err_tick_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
    end
  end

  // Payload buffer, intentionally left without reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign err_tick  = err_tick_q;
  assign err_code  = err_code_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: frame-level expectation model,
// per-cycle compare process, and directed scenarios with literal checks.
module tb_uart_frame_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_done_tick;
  logic [7:0] rx_dout;
  logic       s_tick;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       err_tick;
  logic [1:0] err_code;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_data [$];
  logic [1:0] exp_err  [$];
  logic [7:0] frame_pl [16];
  logic [1:0] last_code;

  uart_frame_rx dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .s_tick       (s_tick),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .err_tick     (err_tick),
    .err_code     (err_code),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame checksum: length plus payload bytes, modulo 256
  function automatic logic [7:0] model_sum(input int n);
    int s;
    s = n;
    for (int i = 0; i < n; i++) s += int'(frame_pl[i]);
    return 8'(s % 256);
  endfunction

  // Frame-level outcome: either a length error, a checksum error, or the payload
  task automatic model_expect(input int n, input int csum);
    if (n == 0 || n > 16) begin
      exp_err.push_back(2'd0);
      return;
    end
`ifdef UART_FRAME_CSUM_EN
    if (csum >= 0 && csum[7:0] != model_sum(n)) begin
      exp_err.push_back(2'd1);
      return;
    end
`endif
    for (int i = 0; i < n; i++) exp_data.push_back({(i == n - 1), frame_pl[i]});
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done_tick = 1'b1;
    rx_dout      = b;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  // csum < 0 sends the correct checksum
  task automatic send_frame(input int n, input int csum);
    model_expect(n, csum);
    send_byte(8'hA5);
    send_byte(8'(n));
    if (n == 0 || n > 16) return;
    for (int i = 0; i < n; i++) send_byte(frame_pl[i]);
`ifdef UART_FRAME_CSUM_EN
    send_byte((csum < 0) ? model_sum(n) : 8'(csum));
`endif
  endtask

  task automatic wait_idle();
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (!busy && !out_valid) return;
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: busy=%0b out_valid=%0b still set after 300 cycles", busy, out_valid);
  endtask

  task automatic tick_cycle();
    s_tick = 1'b1;
    @(posedge clk); #1;
    s_tick = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"},  out_last,  0);
    chk({tag, "_out_data"},  out_data,  0);
    chk({tag, "_err_tick"},  err_tick,  0);
    chk({tag, "_err_code"},  err_code,  0);
    chk({tag, "_busy"},      busy,      0);
  endtask

  // Per-cycle compare against the expectation queues
  logic       prev_stall;
  logic       prev_err;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(negedge clk) begin
    logic [8:0] e;
    logic [1:0] ec;
    if (!reset_n) begin
      prev_stall = 1'b0;
      prev_err   = 1'b0;
      last_code  = 2'd0;
    end else begin
      if (out_valid) chk("valid_implies_busy", busy, 1);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data",  out_data,  prev_data);
        chk("stall_last",  out_last,  prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h last=%0b expected none", out_data, out_last);
        end else begin
          e = exp_data.pop_front();
          chk("out_data", out_data, e[7:0]);
          chk("out_last", out_last, e[8]);
        end
      end
      if (err_tick) begin
        if (prev_err) chk("err_pulse_width", 2, 1);
        if (exp_err.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_err: got code %0d expected none", err_code);
        end else begin
          ec = exp_err.pop_front();
          last_code = ec;
          chk("err_code", err_code, ec);
        end
      end else begin
        chk("err_code_hold", err_code, last_code);
      end
      prev_stall = out_valid && !out_ready;
      prev_err   = err_tick;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    rx_done_tick = 1'b0;
    rx_dout      = 8'h00;
    s_tick       = 1'b0;
    out_ready    = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Good frame, consumer always ready
    frame_pl[0] = 8'h11; frame_pl[1] = 8'h22; frame_pl[2] = 8'h33;
    chk("model_sum_pin1", model_sum(3), 8'h69);
    out_ready = 1'b1;
    send_frame(3, -1);
    chk("lat_valid", out_valid, 1);
    chk("good_d0", out_data, 8'h11);
    chk("good_l0", out_last, 0);
    @(posedge clk); #1;
    chk("good_d1", out_data, 8'h22);
    chk("good_l1", out_last, 0);
    @(posedge clk); #1;
    chk("good_d2", out_data, 8'h33);
    chk("good_l2", out_last, 1);
    @(posedge clk); #1;
    chk("good_done_valid", out_valid, 0);
    chk("good_done_busy", busy, 0);
    wait_idle();

    // Bad checksum (or plain delivery when the checksum stage is absent)
    frame_pl[0] = 8'h10; frame_pl[1] = 8'h20;
`ifdef UART_FRAME_CSUM_EN
    send_frame(2, 8'h00);
    chk("badcsum_tick", err_tick, 1);
    chk("badcsum_code", err_code, 1);
    chk("badcsum_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("badcsum_busy", busy, 0);
`else
    send_frame(2, -1);
`endif
    wait_idle();

    // Bad lengths, then a good frame
    send_frame(0, -1);
    chk("badlen0_tick", err_tick, 1);
    chk("badlen0_code", err_code, 0);
    chk("badlen0_busy", busy, 0);
    @(posedge clk); #1;
    send_frame(17, -1);
    chk("badlen17_tick", err_tick, 1);
    chk("badlen17_code", err_code, 0);
    chk("badlen17_busy", busy, 0);
    @(posedge clk); #1;
    frame_pl[0] = 8'h5A; frame_pl[1] = 8'hC3;
    send_frame(2, -1);
    wait_idle();

    // Timeout fires on the 320th silent tick
    exp_err.push_back(2'd2);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    for (int i = 0; i < 320; i++) begin
      tick_cycle();
      if (i == 318) chk("to_early", err_tick, 0);
      if (i == 319) begin
        chk("to_tick", err_tick, 1);
        chk("to_code", err_code, 2);
      end
      @(posedge clk); #1;
    end
    chk("to_busy", busy, 0);

    // 319 ticks, then a byte coinciding with the 320th tick: no timeout
    frame_pl[0] = 8'h11; frame_pl[1] = 8'h22; frame_pl[2] = 8'h33;
    model_expect(3, -1);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    for (int i = 0; i < 319; i++) begin
      tick_cycle();
      @(posedge clk); #1;
    end
    rx_done_tick = 1'b1;
    rx_dout      = 8'h22;
    s_tick       = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    s_tick       = 1'b0;
    chk("byte_beats_timeout", err_tick, 0);
    chk("byte_beats_timeout_busy", busy, 1);
    send_byte(8'h33);
`ifdef UART_FRAME_CSUM_EN
    send_byte(8'h69);
`endif
    wait_idle();

    // Backpressure with an overrun byte injected mid-delivery
    frame_pl[0] = 8'h01; frame_pl[1] = 8'h02; frame_pl[2] = 8'h03; frame_pl[3] = 8'h04;
    chk("model_sum_pin2", model_sum(4), 8'h0E);
    out_ready = 1'b0;
    send_frame(4, -1);
    exp_err.push_back(2'd3);
    for (int i = 0; i < 12; i++) begin
      out_ready    = (i % 4 == 0) || (i % 4 == 3);
      rx_done_tick = (i == 2);
      rx_dout      = 8'hA5;
      @(posedge clk); #1;
      rx_done_tick = 1'b0;
      if (i == 2) begin
        chk("overrun_tick", err_tick, 1);
        chk("overrun_code", err_code, 3);
        chk("overrun_still_valid", out_valid, 1);
      end
    end
    chk("bp_done_busy", busy, 0);
    wait_idle();

    // Reset in the middle of a payload
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'h02);
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Recovery frame; a byte in the final-handshake cycle is an overrun
    frame_pl[0] = 8'hAA; frame_pl[1] = 8'hBB;
    chk("model_sum_pin3", model_sum(2), 8'h67);
    out_ready = 1'b1;
    send_frame(2, -1);
    chk("rec_first", out_data, 8'hAA);
    @(posedge clk); #1;
    chk("rec_last_data", out_data, 8'hBB);
    chk("rec_last_flag", out_last, 1);
    exp_err.push_back(2'd3);
    rx_done_tick = 1'b1;
    rx_dout      = 8'hA5;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    chk("last_overrun_tick", err_tick, 1);
    chk("last_overrun_code", err_code, 3);
    chk("last_overrun_valid", out_valid, 0);
    chk("last_overrun_busy", busy, 0);
    @(posedge clk); #1;
    chk("no_sof_parse", busy, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("exp_data_drained", exp_data.size(), 0);
    chk("exp_err_drained", exp_err.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
